div_result_fifo: RTL and testbench

- Downstream stage of general_divider: captures each completed quotient/remainder pair when the divider's done rises.
- Buffers results in a small FIFO and presents them to the consumer through a valid/ready interface.
- Reports lost results (overflow) with a sticky flag and a saturating drop counter.

---
 rtl/div_result_fifo.sv | 111 +++++++++++
 tb/tb_div_result_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/div_result_fifo.sv
// Result buffer behind general_divider: captures each quotient/remainder pair on the
// rising edge of div_done and hands it to a valid/ready consumer, counting lost results.
module div_result_fifo #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH_A-1:0]         div_q,
  input  logic [WIDTH_B-1:0]         div_r,
  input  logic                       div_done,
  output logic [WIDTH_A-1:0]         out_q,
  output logic [WIDTH_B-1:0]         out_r,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       clear_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DW    = WIDTH_A + WIDTH_B;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             done_d;
  logic             push;
  logic             pop;
  logic             do_write;
  logic             drop;
  logic [DW-1:0]    head_next;

  // Status flags come only from the registered count, so out_ready never reaches them.
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = ~empty;

  assign push     = div_done & ~done_d;
  assign pop      = out_valid & out_ready;
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  assign rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  // The head register must see a same-cycle write into the slot it is about to present,
  // which is what gives the one-cycle latency into an empty FIFO.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (do_write && (wr_ptr == rd_ptr_next)) begin
      head_next = {div_q, div_r};
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {div_q, div_r};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_d <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_q  <= '0;
      out_r  <= '0;
    end else begin
      done_d <= div_done;
      rd_ptr <= rd_ptr_next;
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_write && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (!do_write && pop) begin
        count <= count - (PTR_W + 1)'(1);
      end
      out_q <= head_next[DW-1:WIDTH_B];
      out_r <= head_next[WIDTH_B-1:0];
    end
  end

  // A drop in the same cycle as clear_ovf restarts the tally at one rather than zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf) begin
        drop_cnt <= CNT_W'(1);
      end else if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end else if (clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_div_result_fifo.sv
// Scoreboard bench for div_result_fifo: stimulus queues expected results, a negedge
// monitor compares every popped head entry, directed checks cover status outputs.
module tb_div_result_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] div_q;
  logic [3:0] div_r;
  logic       div_done;
  logic [7:0] out_q;
  logic [3:0] out_r;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clear_ovf;

  int total = 0;
  int bad   = 0;
  logic [11:0] sb[$];

  div_result_fifo #(.WIDTH_A(8), .WIDTH_B(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .div_q(div_q), .div_r(div_r), .div_done(div_done),
    .out_q(out_q), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .drop_cnt(drop_cnt), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle done pulse followed by an idle cycle; accepted results go to the scoreboard.
  task automatic apply_stimulus(input logic [7:0] q, input logic [3:0] r, input bit accepted);
    if (accepted) sb.push_back({q, r});
    div_q = q;
    div_r = r;
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    tick();
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
    check_output("drain_empty", empty, 1);
    check_output("drain_sb_used", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pop: got q=0x%0h r=0x%0h expected none", out_q, out_r);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        check_output("pop_q", out_q, e[11:4]);
        check_output("pop_r", out_r, e[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    div_q = '0;
    div_r = '0;
    div_done = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    #12;
    check_output("rst_count", count, 0);
    check_output("rst_empty", empty, 1);
    check_output("rst_full", full, 0);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_ovf", overflow, 0);
    check_output("rst_drop", drop_cnt, 0);
    check_output("rst_q", out_q, 0);
    check_output("rst_r", out_r, 0);
    tick();
    reset = 1'b1;
    tick();

    // Single result, one-cycle latency
    sb.push_back({8'h0F, 4'h5});
    div_q = 8'h0F; div_r = 4'h5; div_done = 1'b1;
    tick();
    div_done = 1'b0;
    check_output("single_valid", out_valid, 1);
    check_output("single_q", out_q, 8'h0F);
    check_output("single_r", out_r, 4'h5);
    check_output("single_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("single_empty", empty, 1);
    check_output("single_valid_after", out_valid, 0);

    // Level-held done yields one entry
    sb.push_back({8'h20, 4'h3});
    div_q = 8'h20; div_r = 4'h3; div_done = 1'b1;
    repeat (5) tick();
    div_done = 1'b0;
    check_output("level_count", count, 1);
    tick();
    check_output("level_count2", count, 1);
    drain(1);

    // Fill and overflow
    for (int i = 1; i <= 6; i++) apply_stimulus(8'(i), 4'(i), i <= 4);
    check_output("fill_full", full, 1);
    check_output("fill_count", count, 4);
    check_output("fill_ovf", overflow, 1);
    check_output("fill_drop", drop_cnt, 2);
    drain(4);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check_output("clr_ovf", overflow, 0);
    check_output("clr_drop", drop_cnt, 0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(i), 4'(i), 1'b1);
    sb.push_back({8'h09, 4'h9});
    div_q = 8'h09; div_r = 4'h9; div_done = 1'b1; out_ready = 1'b1;
    tick();
    div_done = 1'b0; out_ready = 1'b0;
    check_output("pp_count", count, 4);
    check_output("pp_full", full, 1);
    check_output("pp_ovf", overflow, 0);
    check_output("pp_drop", drop_cnt, 0);
    tick();
    drain(4);

    // Clear versus drop in the same cycle
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(i + 16), 4'(i), 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(8'hEE, 4'hE, 1'b0);
    check_output("cd_ovf_pre", overflow, 1);
    check_output("cd_drop_pre", drop_cnt, 3);
    div_q = 8'hDD; div_r = 4'hD; div_done = 1'b1; clear_ovf = 1'b1;
    tick();
    div_done = 1'b0; clear_ovf = 1'b0;
    check_output("cd_ovf", overflow, 1);
    check_output("cd_drop", drop_cnt, 1);
    check_output("cd_count", count, 4);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check_output("cd_ovf_clr", overflow, 0);
    check_output("cd_drop_clr", drop_cnt, 0);

    // Saturating drop counter
    for (int i = 0; i < 260; i++) apply_stimulus(8'hAA, 4'hA, 1'b0);
    check_output("sat_drop", drop_cnt, 255);
    check_output("sat_ovf", overflow, 1);
    check_output("sat_count", count, 4);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    drain(4);

    // Asynchronous reset mid-stream
    for (int i = 1; i <= 3; i++) apply_stimulus(8'(i + 32), 4'(i), 1'b1);
    check_output("ar_count_pre", count, 3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    sb.delete();
    check_output("ar_count", count, 0);
    check_output("ar_valid", out_valid, 0);
    check_output("ar_empty", empty, 1);
    check_output("ar_ovf", overflow, 0);
    tick();
    reset = 1'b1;
    tick();
    sb.push_back({8'h0F, 4'h5});
    div_q = 8'h0F; div_r = 4'h5; div_done = 1'b1;
    tick();
    div_done = 1'b0;
    check_output("ar_single_valid", out_valid, 1);
    check_output("ar_single_q", out_q, 8'h0F);
    check_output("ar_single_r", out_r, 4'h5);
    check_output("ar_single_count", count, 1);
    drain(1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
